// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared FSM state type and framing constants.
// Optional checksum stage is selected by PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream handshake plus instruction-memory write port.
// master = stream source / memory side, slave = loader.
interface prog_loader_if #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned D_WIDTH = 32
);

    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic               mem_we;
    logic [A_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0] mem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: collects four stream bytes into a little-endian word.
// word/word_full include the byte being pushed this cycle.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  din,
    output logic        word_full,
    output logic [31:0] word
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] sreg_q, sreg_d;

    // New bytes enter at the top so the first byte ends in bits [7:0]
    always_comb begin
        lane_d = lane_q;
        sreg_d = sreg_q;
        if (clr) begin
            lane_d = '0;
            sreg_d = '0;
        end else if (push) begin
            lane_d = lane_q + 2'd1;
            sreg_d = {din, sreg_q[31:8]};
        end
    end

    // Lane counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            sreg_q <= '0;
        end else begin
            lane_q <= lane_d;
            sreg_q <= sreg_d;
        end
    end

    assign word_full = push && !clr
                       && (lane_q == 2'(BYTES_PER_WORD - 1));
    assign word      = {din, sreg_q[31:8]};

endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte stream to instruction memory, CPU held in reset.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned        A_WIDTH   = 32,
    parameter int unsigned        D_WIDTH   = 32,
    parameter int unsigned        MEM_WORDS = 256,
    parameter logic [A_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus,
    input  logic         reload,
    output logic         cpu_rst,
    output logic         done,
    output logic         err
);

    loader_state_t state_q, state_d;

    logic [7:0]         hdr_lo_q, hdr_lo_d;
    logic [15:0]        count_q, count_d;
    logic [A_WIDTH-1:0] word_idx_q, word_idx_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               byte_ready_q, byte_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic        accept;
    logic        take_reload;
    logic        push;
    logic        word_full;
    logic [31:0] word;
    logic [15:0] hdr_count;

    assign accept      = bus.byte_valid && byte_ready_q;
    assign take_reload = reload && (state_q == DONE || state_q == ERR);
    assign push        = accept && (state_q == DATA);
    assign hdr_count   = {bus.byte_data, hdr_lo_q};

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (take_reload),
        .push      (push),
        .din       (bus.byte_data),
        .word_full (word_full),
        .word      (word)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HDR0;
            hdr_lo_q   <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_lo_q   <= hdr_lo_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Frame sequencing: header, data words, optional checksum, end state
    always_comb begin
        state_d    = state_q;
        hdr_lo_d   = hdr_lo_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            HDR0: begin
                if (accept) begin
                    hdr_lo_d = bus.byte_data;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    count_d = hdr_count;
                    if (hdr_count == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else if (32'(hdr_count) > MEM_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (accept) begin
                    csum_d = csum_q + bus.byte_data;
                end
`endif
                if (word_full) begin
                    state_d    = WRITE;
                    word_idx_d = word_idx_q + A_WIDTH'(1);
                end
            end
            WRITE: begin
                if (word_idx_q == A_WIDTH'(count_q)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
            CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_d = (bus.byte_data == csum_q) ? DONE : ERR;
                end
`else
                state_d = HDR0;
`endif
            end
            DONE, ERR: begin
                if (reload) begin
                    state_d    = HDR0;
                    word_idx_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            default: state_d = HDR0;
        endcase
    end

    // Registered outputs follow the state being entered
    always_comb begin
        byte_ready_d = (state_d == HDR0) || (state_d == HDR1)
                    || (state_d == DATA) || (state_d == CSUM);
        mem_we_d     = (state_d == WRITE);
        cpu_rst_d    = (state_d != DONE);
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERR);
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if (word_full) begin
            mem_addr_d  = BASE_ADDR + (word_idx_q << 2);
            mem_wdata_d = D_WIDTH'(word);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign cpu_rst        = cpu_rst_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
